// File: rtl/cellrv32_io_gateway.sv
// cellrv32_io_gateway: single-outstanding bridge from the CPU data bus to the IO device window.
// Bus timeout terminates accesses that no device answers.
module cellrv32_io_gateway #(
    parameter logic [31:0] IO_BASE     = 32'hFFFFFE00,
    parameter int          IO_SIZE     = 512,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] host_addr_i,
    input  logic        host_rden_i,
    input  logic        host_wren_i,
    input  logic [3:0]  host_ben_i,
    input  logic [31:0] host_data_i,
    output logic [31:0] host_data_o,
    output logic        host_ack_o,
    output logic        host_err_o,
    output logic [31:0] io_addr_o,
    output logic        io_rden_o,
    output logic        io_wren_o,
    output logic [3:0]  io_ben_o,
    output logic [31:0] io_data_o,
    input  logic [31:0] io_data_i,
    input  logic        io_ack_i,
    input  logic        io_err_i,
    output logic        busy_o,
    output logic        timeout_o
);
    localparam int AW = $clog2(IO_SIZE);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          is_wr, is_wr_nxt;
    logic [31:0]   addr_nxt, wdata_nxt, rdata_nxt;
    logic [3:0]    ben_nxt;
    logic          rden_nxt, wren_nxt, ack_nxt, err_nxt, tmo_nxt;
    logic          req;

    assign req    = (host_rden_i | host_wren_i) && (host_addr_i[31:AW] == IO_BASE[31:AW]);
    assign busy_o = (state == BUSY);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        is_wr_nxt = is_wr;
        addr_nxt  = io_addr_o;
        ben_nxt   = io_ben_o;
        wdata_nxt = io_data_o;
        rdata_nxt = '0;
        rden_nxt  = 1'b0;
        wren_nxt  = 1'b0;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        tmo_nxt   = 1'b0;
        if (state == IDLE) begin
            if (req) begin
                // a simultaneous read+write strobe is issued as a write
                state_nxt = BUSY;
                cnt_nxt   = '0;
                is_wr_nxt = host_wren_i;
                addr_nxt  = host_addr_i;
                ben_nxt   = host_ben_i;
                wdata_nxt = host_data_i;
                wren_nxt  = host_wren_i;
                rden_nxt  = ~host_wren_i;
            end
        end else if (io_err_i) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end else if (io_ack_i) begin
            state_nxt = IDLE;
            ack_nxt   = 1'b1;
            rdata_nxt = is_wr ? '0 : io_data_i;
        end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
            tmo_nxt   = 1'b1;
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            cnt         <= '0;
            is_wr       <= 1'b0;
            io_addr_o   <= '0;
            io_ben_o    <= '0;
            io_data_o   <= '0;
            io_rden_o   <= 1'b0;
            io_wren_o   <= 1'b0;
            host_data_o <= '0;
            host_ack_o  <= 1'b0;
            host_err_o  <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            is_wr       <= is_wr_nxt;
            io_addr_o   <= addr_nxt;
            io_ben_o    <= ben_nxt;
            io_data_o   <= wdata_nxt;
            io_rden_o   <= rden_nxt;
            io_wren_o   <= wren_nxt;
            host_data_o <= rdata_nxt;
            host_ack_o  <= ack_nxt;
            host_err_o  <= err_nxt;
            timeout_o   <= tmo_nxt;
        end
    end
endmodule

// File: tb/tb_cellrv32_io_gateway.sv
// tb_cellrv32_io_gateway: directed bench with a transaction-level reference model
// checked against the gateway on every falling clock edge.
module tb_cellrv32_io_gateway;
    localparam int TMO = 8;
    localparam longint unsigned BASE = 64'hFFFFFE00;
    localparam longint unsigned SIZE = 64'd512;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [31:0] host_addr_i = '0;
    logic        host_rden_i = 1'b0;
    logic        host_wren_i = 1'b0;
    logic [3:0]  host_ben_i = '0;
    logic [31:0] host_data_i = '0;
    logic [31:0] host_data_o;
    logic        host_ack_o, host_err_o;
    logic [31:0] io_addr_o;
    logic        io_rden_o, io_wren_o;
    logic [3:0]  io_ben_o;
    logic [31:0] io_data_o;
    logic [31:0] io_data_i = '0;
    logic        io_ack_i = 1'b0;
    logic        io_err_i = 1'b0;
    logic        busy_o, timeout_o;

    int checks = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    cellrv32_io_gateway #(.IO_BASE(32'hFFFFFE00), .IO_SIZE(512), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .host_addr_i(host_addr_i), .host_rden_i(host_rden_i), .host_wren_i(host_wren_i),
        .host_ben_i(host_ben_i), .host_data_i(host_data_i),
        .host_data_o(host_data_o), .host_ack_o(host_ack_o), .host_err_o(host_err_o),
        .io_addr_o(io_addr_o), .io_rden_o(io_rden_o), .io_wren_o(io_wren_o),
        .io_ben_o(io_ben_o), .io_data_o(io_data_o),
        .io_data_i(io_data_i), .io_ack_i(io_ack_i), .io_err_i(io_err_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, aged in whole BUSY cycles.
    bit          m_busy;
    int          m_age;
    bit          m_wr;
    logic [31:0] m_addr, m_data, e_rdata;
    logic [3:0]  m_ben;
    bit          e_rden, e_wren, e_ack, e_err, e_tmo;

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            m_busy <= 0; m_age <= 0; m_wr <= 0;
            m_addr <= '0; m_data <= '0; m_ben <= '0; e_rdata <= '0;
            e_rden <= 0; e_wren <= 0; e_ack <= 0; e_err <= 0; e_tmo <= 0;
        end else begin
            e_rden <= 0; e_wren <= 0; e_ack <= 0; e_err <= 0; e_tmo <= 0; e_rdata <= '0;
            if (!m_busy) begin
                if ((host_rden_i || host_wren_i) && 64'(host_addr_i) >= BASE && 64'(host_addr_i) < BASE + SIZE) begin
                    m_busy <= 1; m_age <= 1; m_wr <= host_wren_i;
                    m_addr <= host_addr_i; m_ben <= host_ben_i; m_data <= host_data_i;
                    e_wren <= host_wren_i; e_rden <= !host_wren_i;
                end
            end else if (io_err_i) begin
                m_busy <= 0; e_err <= 1;
            end else if (io_ack_i) begin
                m_busy <= 0; e_ack <= 1; e_rdata <= m_wr ? 32'h0 : io_data_i;
            end else if (m_age == TMO) begin
                m_busy <= 0; e_err <= 1; e_tmo <= 1;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    always @(negedge clk_i) begin
        chk("busy", busy_o, m_busy);
        chk("io_rden", io_rden_o, e_rden);
        chk("io_wren", io_wren_o, e_wren);
        chk("io_addr", io_addr_o, m_addr);
        chk("io_ben", io_ben_o, m_ben);
        chk("io_data", io_data_o, m_data);
        chk("host_ack", host_ack_o, e_ack);
        chk("host_err", host_err_o, e_err);
        chk("timeout", timeout_o, e_tmo);
        chk("host_data", host_data_o, e_rdata);
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        host_rden_i = rd; host_wren_i = wr; host_addr_i = a; host_ben_i = b; host_data_i = d;
    endtask

    task automatic release_host;
        host_rden_i = 0; host_wren_i = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_io_addr", io_addr_o, 0);
        chk("rst_host_ack", host_ack_o, 0);
        rstn_i = 1;
        tick;

        // read with 1-cycle device ack, then back-to-back write at the window base
        drive(1, 0, 32'hFFFFFF90, 4'hF, 32'h0);
        tick; release_host;
        chk("rd_strobe", io_rden_o, 1);
        chk("rd_addr", io_addr_o, 32'hFFFFFF90);
        tick; io_ack_i = 1; io_data_i = 32'h12345678;
        tick; io_ack_i = 0; io_data_i = 0;
        chk("rd_ack", host_ack_o, 1);
        chk("rd_data", host_data_o, 32'h12345678);
        drive(0, 1, 32'hFFFFFE00, 4'h3, 32'hA5A5A5A5);
        tick; release_host;
        chk("b2b_wren", io_wren_o, 1);
        chk("b2b_ben", io_ben_o, 4'h3);
        tick; io_ack_i = 1; io_data_i = 32'hFFFFFFFF;
        tick; io_ack_i = 0; io_data_i = 0;
        chk("b2b_ack", host_ack_o, 1);
        chk("b2b_data", host_data_o, 0);
        tick;

        // read+write together is a write
        drive(1, 1, 32'hFFFFFF98, 4'hF, 32'hCAFEBABE);
        tick; release_host;
        chk("wr_wren", io_wren_o, 1);
        chk("wr_no_rden", io_rden_o, 0);
        chk("wr_data", io_data_o, 32'hCAFEBABE);
        tick; io_ack_i = 1; io_data_i = 32'h11111111;
        tick; io_ack_i = 0; io_data_i = 0;
        chk("wr_ack", host_ack_o, 1);
        chk("wr_rdata0", host_data_o, 0);
        tick;
        chk("wr_hold", io_data_o, 32'hCAFEBABE);

        // no device answer: timeout, then stray ack ignored
        drive(1, 0, 32'hFFFFFFA0, 4'hF, 0);
        tick; release_host;
        n = 0;
        while (busy_o && n < 20) begin n++; tick; end
        chk("tmo_busy_len", n, TMO);
        chk("tmo_err", host_err_o, 1);
        chk("tmo_flag", timeout_o, 1);
        tick;
        io_ack_i = 1; io_data_i = 32'hBAD0BAD0;
        tick; io_ack_i = 0; io_data_i = 0;
        chk("stray_ack", host_ack_o, 0);
        chk("stray_busy", busy_o, 0);
        tick;

        // ack in the last counted BUSY cycle wins
        drive(1, 0, 32'hFFFFFFA4, 4'hF, 0);
        tick; release_host;
        repeat (TMO - 1) tick;
        chk("late_still_busy", busy_o, 1);
        io_ack_i = 1; io_data_i = 32'h0000BEEF;
        tick; io_ack_i = 0; io_data_i = 0;
        chk("late_ack", host_ack_o, 1);
        chk("late_no_err", host_err_o, 0);
        chk("late_no_tmo", timeout_o, 0);
        chk("late_data", host_data_o, 32'h0000BEEF);
        tick;

        // err beats a simultaneous ack
        drive(0, 1, 32'hFFFFFFA8, 4'h1, 32'h5);
        tick; release_host;
        tick; io_ack_i = 1; io_err_i = 1;
        tick; io_ack_i = 0; io_err_i = 0;
        chk("both_err", host_err_o, 1);
        chk("both_no_ack", host_ack_o, 0);
        chk("both_no_tmo", timeout_o, 0);
        tick;

        // out of window, including just below the base
        drive(1, 0, 32'h80000000, 4'hF, 0);
        tick;
        chk("oow_no_strobe", io_rden_o, 0);
        chk("oow_busy", busy_o, 0);
        drive(0, 1, 32'hFFFFFDFC, 4'hF, 32'h77);
        tick; release_host;
        chk("oow2_no_strobe", io_wren_o, 0);
        tick;

        // second strobe while busy is dropped
        drive(1, 0, 32'hFFFFFFB0, 4'hF, 0);
        tick;
        drive(1, 0, 32'hFFFFFFB4, 4'hF, 0);
        tick; release_host;
        chk("drop_no_strobe", io_rden_o, 0);
        chk("drop_addr", io_addr_o, 32'hFFFFFFB0);
        io_ack_i = 1; io_data_i = 32'h00C0FFEE;
        tick; io_ack_i = 0; io_data_i = 0;
        chk("drop_ack", host_ack_o, 1);
        n = 0;
        repeat (4) begin tick; n += int'(host_ack_o) + int'(io_rden_o); end
        chk("drop_extra", n, 0);

        // async reset in mid-BUSY
        drive(1, 0, 32'hFFFFFF80, 4'hF, 0);
        tick; release_host;
        tick;
        #2 rstn_i = 0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_addr", io_addr_o, 0);
        chk("arst_ben", io_ben_o, 0);
        io_ack_i = 1;
        tick; io_ack_i = 0;
        tick; rstn_i = 1;
        tick;
        chk("arst_no_ack", host_ack_o, 0);
        chk("arst_no_err", host_err_o, 0);
        drive(1, 0, 32'hFFFFFF84, 4'hF, 0);
        tick; release_host;
        chk("post_rden", io_rden_o, 1);
        tick; io_ack_i = 1; io_data_i = 32'hDEADBEEF;
        tick; io_ack_i = 0; io_data_i = 0;
        chk("post_ack", host_ack_o, 1);
        chk("post_data", host_data_o, 32'hDEADBEEF);
        tick; tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
